// File: rtl/serializer_arbiter_if.sv
// rtl/serializer_arbiter_if.sv - requester and serializer signal bundle for serializer_arbiter
// master is the arbiter side; slave is the requesters plus the serializer.
interface serializer_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
) ();
   localparam int ID_WIDTH = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            ack;
   logic [ID_WIDTH-1:0]           grant_id;
   logic                          active;
   logic                          ser_start;
   logic [DATA_WIDTH-1:0]         ser_data;
   logic                          ser_busy;

   modport master (
      input  req, req_data, ser_busy,
      output ack, grant_id, active, ser_start, ser_data
   );

   modport slave (
      output req, req_data, ser_busy,
      input  ack, grant_id, active, ser_start, ser_data
   );
endinterface

// File: rtl/serializer_arbiter.sv
// rtl/serializer_arbiter.sv - round-robin arbiter sharing one serializer among NUM_REQ requesters
// IDLE grants and captures a word, LAUNCH issues one start strobe, SHIFT waits for the frame to end.
module serializer_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
) (
   input logic                  clock,
   input logic                  reset,
   serializer_arbiter_if.master bus
);
   localparam int ID_WIDTH = $clog2(NUM_REQ);
   localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      SHIFT
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [ID_WIDTH-1:0]     ptr;
   logic [ID_WIDTH-1:0]     grant_q;
   logic [NUM_REQ-1:0]      ack_q;
   logic [DATA_WIDTH-1:0]   hold;
   logic                    launched;

   logic [DATA_WIDTH-1:0]   words [NUM_REQ];
   logic [ID_WIDTH-1:0]     winner;
   logic                    winner_found;
   logic [ID_WIDTH-1:0]     cand;
   logic                    grant;
   logic                    start;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         words[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Walk forward from the last grant so the previous winner is checked last.
   always_comb begin
      winner_found = 1'b0;
      winner       = '0;
      cand         = ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
         if (!winner_found && bus.req[cand]) begin
            winner_found = 1'b1;
            winner       = cand;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Start fires at most once per frame: a serializer still busy from an
   // earlier frame holds us in LAUNCH without being mistaken for our own frame.
   always_comb begin
      state_next = state;
      grant      = 1'b0;
      start      = 1'b0;
      case (state)
         IDLE: begin
            if (winner_found) begin
               grant      = 1'b1;
               state_next = LAUNCH;
            end
         end
         LAUNCH: begin
            start = !launched && !bus.ser_busy;
            if (launched && bus.ser_busy) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (!bus.ser_busy) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ack_q    <= '0;
         hold     <= '0;
         grant_q  <= '0;
         ptr      <= LAST_ID;
         launched <= 1'b0;
      end else begin
         ack_q <= '0;
         if (grant) begin
            ack_q    <= NUM_REQ'(1) << winner;
            hold     <= words[winner];
            grant_q  <= winner;
            ptr      <= winner;
            launched <= 1'b0;
         end else if (start) begin
            launched <= 1'b1;
         end
      end
   end

   assign bus.ack       = ack_q;
   assign bus.grant_id  = grant_q;
   assign bus.active    = (state != IDLE);
   assign bus.ser_start = start;
   assign bus.ser_data  = hold;
endmodule
